// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl -- time-set sequencer for the multi-function digital clock.
// Walks RUN -> SET_HR -> SET_MIN -> SET_SEC on S3 pulses. It turns S4 pulses into
// one-cycle increment/clear strobes for the field under edit, gates the time
// counters with run_en, and drives the display blink controls. An idle timeout
// returns to RUN when no key has been pressed for a while.
// Optional feature macro: AUTO_REPEAT_EN (hold S4 to auto-repeat in SET_HR/SET_MIN).
module clock_set_ctrl #(
  parameter int BLINK_DIV    = 50,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_p,
  input  logic       inc_p,
  input  logic       inc_lvl,
  input  logic       en_lvl,
  output logic [1:0] state,
  output logic       run_en,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       clr_sec,
  output logic [2:0] blink_mask,
  output logic       blink_on
);

  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_SET_SEC = 2'b11
  } state_t;

  state_t               state_r;
  logic [BLINK_W-1:0]   blink_cnt_r;
  logic [IDLE_W-1:0]    idle_cnt_r;

  logic in_set_s;      // currently editing a field
  logic rep_strobe_s;  // auto-repeat wants a strobe this cycle
  logic key_act_s;     // any key activity that restarts the idle timer
  logic inc_fire_s;    // an increment is accepted this cycle
  logic timeout_s;     // idle timer expires this cycle

  // Next field in the mode walk; wraps back to RUN after seconds.
  function automatic state_t step_state(input state_t s);
    case (s)
      ST_RUN:     return ST_SET_HR;
      ST_SET_HR:  return ST_SET_MIN;
      ST_SET_MIN: return ST_SET_SEC;
      ST_SET_SEC: return ST_RUN;
      default:    return ST_RUN;
    endcase
  endfunction

  // One-hot {hr,min,sec} blink mask for a given state.
  function automatic logic [2:0] mask_of(input state_t s);
    case (s)
      ST_SET_HR:  return 3'b100;
      ST_SET_MIN: return 3'b010;
      ST_SET_SEC: return 3'b001;
      ST_RUN:     return 3'b000;
      default:    return 3'b000;
    endcase
  endfunction

  assign state = state_r;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int REP_W  = $clog2(REPEAT_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(HOLD_TICKS);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

  logic [HOLD_W-1:0] hold_cnt_r;  // saturates at HOLD_TICKS once the first repeat fired
  logic [REP_W-1:0]  rep_cnt_r;   // ticks since the last repeat strobe
  logic              hold_ok_s;

  // Decide whether a held S4 produces a repeat strobe on this tick.
  always_comb begin
    hold_ok_s = ((state_r == ST_SET_HR) | (state_r == ST_SET_MIN)) & inc_lvl & ~mode_p;
    if (hold_ok_s & tick) begin
      rep_strobe_s = (hold_cnt_r == HOLD_LAST) |
                     ((hold_cnt_r == HOLD_DONE) & (rep_cnt_r == REP_LAST));
    end else begin
      rep_strobe_s = 1'b0;
    end
  end

  // Track how long S4 has been held; restart on release, state change or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_r <= '0;
      rep_cnt_r  <= '0;
    end else if (~hold_ok_s | timeout_s) begin
      hold_cnt_r <= '0;
      rep_cnt_r  <= '0;
    end else if (tick) begin
      if (hold_cnt_r == HOLD_DONE) begin
        if (rep_cnt_r == REP_LAST) begin
          rep_cnt_r <= '0;
        end else begin
          rep_cnt_r <= rep_cnt_r + REP_W'(1);
        end
      end else begin
        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end
    end else begin
      hold_cnt_r <= hold_cnt_r;
      rep_cnt_r  <= rep_cnt_r;
    end
  end
`else
  // Without auto-repeat the held level and repeat timing have no effect.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = inc_lvl ^ (HOLD_TICKS > 0) ^ (REPEAT_TICKS > 0);
  assign rep_strobe_s = 1'b0;
`endif

  // Derive the per-cycle key, increment and timeout events.
  always_comb begin
    in_set_s   = (state_r != ST_RUN);
    key_act_s  = mode_p | inc_p | rep_strobe_s;
    inc_fire_s = in_set_s & ~mode_p & (inc_p | rep_strobe_s);
    timeout_s  = in_set_s & tick & ~key_act_s & (idle_cnt_r == IDLE_LAST);
  end

  // Mode FSM with registered state, strobes, run enable and blink mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      run_en     <= 1'b0;
      inc_hr     <= 1'b0;
      inc_min    <= 1'b0;
      clr_sec    <= 1'b0;
      blink_mask <= 3'b000;
    end else begin
      inc_hr  <= inc_fire_s & (state_r == ST_SET_HR);
      inc_min <= inc_fire_s & (state_r == ST_SET_MIN);
      clr_sec <= inc_fire_s & (state_r == ST_SET_SEC);
      if (mode_p) begin
        state_r    <= step_state(state_r);
        blink_mask <= mask_of(step_state(state_r));
        run_en     <= (step_state(state_r) == ST_RUN) & ~en_lvl;
      end else if (timeout_s) begin
        state_r    <= ST_RUN;
        blink_mask <= 3'b000;
        run_en     <= ~en_lvl;
      end else begin
        state_r    <= state_r;
        blink_mask <= mask_of(state_r);
        run_en     <= (state_r == ST_RUN) & ~en_lvl;
      end
    end
  end

  // Blink phase: toggle every BLINK_DIV ticks while editing, show field on any activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r <= '0;
      blink_on    <= 1'b1;
    end else if (mode_p | timeout_s | inc_fire_s | ~in_set_s) begin
      blink_cnt_r <= '0;
      blink_on    <= 1'b1;
    end else if (tick) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= '0;
        blink_on    <= ~blink_on;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        blink_on    <= blink_on;
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
      blink_on    <= blink_on;
    end
  end

  // Idle timer: ticks since the last key while editing; never passes IDLE_TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_r <= '0;
    end else if (key_act_s | timeout_s | ~in_set_s) begin
      idle_cnt_r <= '0;
    end else if (tick) begin
      idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl: directed scenarios followed by random stimulus.
// A behavioural model predicts the outputs after every edge; a monitor compares.
// Build with +define+AUTO_REPEAT_EN to exercise the auto-repeat variant.
module tb_clock_set_ctrl;

  localparam int BLINK_DIV    = 50;
  localparam int IDLE_TIMEOUT = 1000;
  localparam int HOLD_TICKS   = 50;
  localparam int REPEAT_TICKS = 10;

  logic       clk = 1'b0;
  logic       rst, tick, mode_p, inc_p, inc_lvl, en_lvl;
  logic [1:0] state;
  logic       run_en, inc_hr, inc_min, clr_sec;
  logic [2:0] blink_mask;
  logic       blink_on;

  typedef struct packed {
    logic [1:0] st;
    logic       run;
    logic [2:0] str;   // {inc_hr, inc_min, clr_sec}
    logic [2:0] mask;
    logic       on;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: field index (0 RUN, 1 hr, 2 min, 3 sec) and elapsed-tick counts.
  int m_field = 0;
  int m_idle  = 0;   // ticks since last key activity while editing
  int m_blink = 0;   // ticks since blink phase restart
  int m_hold  = 0;   // ticks S4 has been held in an eligible state

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .BLINK_DIV(BLINK_DIV), .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_p(mode_p), .inc_p(inc_p),
    .inc_lvl(inc_lvl), .en_lvl(en_lvl), .state(state), .run_en(run_en),
    .inc_hr(inc_hr), .inc_min(inc_min), .clr_sec(clr_sec),
    .blink_mask(blink_mask), .blink_on(blink_on)
  );

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's prediction for the next edge.
  task automatic cycle(input logic r, input logic t, input logic m, input logic i,
                       input logic l, input logic e);
    exp_t x;
    bit   in_set, rep, fire, tmo;
    int   nxt;
    @(negedge clk);
    rst = r; tick = t; mode_p = m; inc_p = i; inc_lvl = l; en_lvl = e;
    if (r) begin
      m_field = 0; m_idle = 0; m_blink = 0; m_hold = 0;
      x.st = 2'd0; x.run = 1'b0; x.str = 3'b000; x.mask = 3'b000; x.on = 1'b1;
    end else begin
      in_set = (m_field != 0);
      rep = 1'b0;
`ifdef AUTO_REPEAT_EN
      if ((m_field == 1 || m_field == 2) && l && !m && t) begin
        int h;
        h = m_hold + 1;
        rep = (h == HOLD_TICKS) ||
              (h > HOLD_TICKS && ((h - HOLD_TICKS) % REPEAT_TICKS) == 0);
      end
`endif
      fire = in_set && !m && (i || rep);
      tmo  = in_set && t && !m && !i && !rep && (m_idle + 1 == IDLE_TIMEOUT);
      nxt  = m ? (m_field + 1) % 4 : (tmo ? 0 : m_field);
      if ((m_field == 1 || m_field == 2) && l && !m && !tmo) m_hold += int'(t);
      else m_hold = 0;
      if (m || i || rep || tmo || !in_set) m_idle = 0;
      else m_idle += int'(t);
      if (m || tmo || fire || !in_set) m_blink = 0;
      else m_blink += int'(t);
      x.st   = 2'(nxt);
      x.run  = (nxt == 0) && !e;
      x.str  = {fire && m_field == 1, fire && m_field == 2, fire && m_field == 3};
      x.mask = (nxt == 1) ? 3'b100 : (nxt == 2) ? 3'b010 : (nxt == 3) ? 3'b001 : 3'b000;
      x.on   = ((m_blink / BLINK_DIV) % 2) == 0;
      m_field = nxt;
    end
    sb_q.push_back(x);
  endtask

  task automatic idle_cycles(input int n, input logic t);
    for (int k = 0; k < n; k++) cycle(1'b0, t, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: after every active edge, pop one prediction and compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("state", int'(state), int'(e.st));
        cmp("run_en", int'(run_en), int'(e.run));
        cmp("strobes", int'({inc_hr, inc_min, clr_sec}), int'(e.str));
        cmp("blink_mask", int'(blink_mask), int'(e.mask));
        cmp("blink_on", int'(blink_on), int'(e.on));
      end
    end
  end

  // Stimulus: directed scenarios then two random phases.
  initial begin
    logic lvl_r, en_r;
    rst = 1'b1; tick = 1'b0; mode_p = 1'b0; inc_p = 1'b0; inc_lvl = 1'b0; en_lvl = 1'b0;

    // Reset for two cycles, then release.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);

    // Full mode walk, pulses 5 cycles apart.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycles(4, 1'b0);
    end

    // SET_MIN: three increments, then mode and inc together.
    repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_cycles(2, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);

    // Back to RUN, into SET_HR, then no keys until the idle timeout.
    repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(1010, 1'b1);

    // Pause in RUN, then seconds clear in SET_SEC.
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycles(1, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);

    // SET_HR with S4 held for 85 ticks (repeats only with AUTO_REPEAT_EN).
    repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (85) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(5, 1'b1);

    // Random phase A: busy keys.
    lvl_r = 1'b0; en_r = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 59) == 0) lvl_r = ~lvl_r;
      if ($urandom_range(0, 99) == 0) en_r = ~en_r;
      cycle($urandom_range(0, 1999) == 0, $urandom_range(0, 1) == 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, lvl_r, en_r);
    end

    // Random phase B: sparse keys so timeouts and long holds occur.
    for (int n = 0; n < 16000; n++) begin
      if ($urandom_range(0, 199) == 0) lvl_r = ~lvl_r;
      if ($urandom_range(0, 299) == 0) en_r = ~en_r;
      cycle($urandom_range(0, 7999) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2499) == 0, $urandom_range(0, 1199) == 0, lvl_r, en_r);
    end

    idle_cycles(3, 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
